arm_pipe_stage_reg: RTL and testbench

Generic elastic pipeline register that supersedes the fixed-field stage registers between ARM pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a parametrised control bundle and data bundle.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so backpressure (hazard stall) never combinationally couples in_ready to out_ready.
- Synchronous flush kills in-flight entries and zeroes their control bits (bubble insertion for branch taken).

---
 rtl/arm_pipe_pkg.sv | 36 +++
 rtl/arm_pipe_entry.sv | 40 ++++
 rtl/arm_pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_arm_pipe_stage_reg.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared widths, bundle field offsets and occupancy encoding for the ARM pipeline stage registers.
package arm_pipe_pkg;

    localparam int unsigned IF_ID_CTRL_W  = 1;
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_CTRL_W  = 9;
    localparam int unsigned ID_EX_DATA_W  = 144;
    localparam int unsigned EX_MEM_CTRL_W = 3;
    localparam int unsigned EX_MEM_DATA_W = 68;
    localparam int unsigned MEM_WB_CTRL_W = 2;
    localparam int unsigned MEM_WB_DATA_W = 68;

    // ID/EX control bundle bit positions
    localparam int unsigned CTRL_EXE_CMD_LSB = 0;
    localparam int unsigned CTRL_S           = 4;
    localparam int unsigned CTRL_B           = 5;
    localparam int unsigned CTRL_MEM_W_EN    = 6;
    localparam int unsigned CTRL_MEM_R_EN    = 7;
    localparam int unsigned CTRL_WB_EN       = 8;

    // ID/EX data bundle LSB positions; bits [143:141] are spare
    localparam int unsigned DATA_SR_LSB      = 0;
    localparam int unsigned DATA_DEST_LSB    = 4;
    localparam int unsigned DATA_SIMM24_LSB  = 8;
    localparam int unsigned DATA_SHIFT_LSB   = 32;
    localparam int unsigned DATA_IMM         = 44;
    localparam int unsigned DATA_VAL_RM_LSB  = 45;
    localparam int unsigned DATA_VAL_RN_LSB  = 77;
    localparam int unsigned DATA_PC_LSB      = 109;

    // Encoding doubles as the occupancy count
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/arm_pipe_entry.sv
// One storage slot of the stage register: valid flag plus control and data bundles.
module arm_pipe_entry #(
    parameter int unsigned CTRL_W     = 9,
    parameter int unsigned DATA_W     = 144,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kill,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // kill beats load beats drop; drop only invalidates, payload is left as is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (CLEAR_DATA) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/arm_pipe_stage_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer and synchronous flush.
module arm_pipe_stage_reg
    import arm_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = ID_EX_CTRL_W,
    parameter int unsigned DATA_W     = ID_EX_DATA_W,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level,
    output logic              flush_kill
);

    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_src_data;
    logic              acc, pop;
    logic              main_load, main_drop, skid_load, skid_drop;
    logic [1:0]        state_q, state_d;
    logic              flush_kill_d;

    // skid_valid is a flop, so out_ready never reaches in_ready combinationally
    assign in_ready  = ~skid_valid;
    assign acc       = in_valid & in_ready;
    assign pop       = main_valid & out_ready;

    assign main_load = (skid_valid & pop) | (acc & (~main_valid | pop));
    assign main_drop = pop;
    assign skid_load = acc & main_valid & ~pop;
    assign skid_drop = skid_valid & pop;

    assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign main_src_data = skid_valid ? skid_data : in_data;

    arm_pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .kill    (flush),
        .load    (main_load),
        .drop    (main_drop),
        .in_ctrl (main_src_ctrl),
        .in_data (main_src_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    arm_pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .kill    (flush),
        .load    (skid_load),
        .drop    (skid_drop),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (acc) state_d = ST_ONE;
                ST_ONE: begin
                    if (acc && !pop) begin
                        state_d = ST_FULL;
                    end else if (!acc && pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // A lone main entry popped during the flush was delivered, not killed
    assign flush_kill_d = flush & (skid_valid | in_valid | (main_valid & ~pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            flush_kill <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_kill <= flush_kill_d;
        end
    end

    assign level     = state_q;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

endmodule

// File: tb/tb_arm_pipe_stage_reg.sv
// Randomised bench for arm_pipe_stage_reg against a FIFO-queue reference model.
module tb_arm_pipe_stage_reg;

    localparam int unsigned CW = 9;
    localparam int unsigned DW = 144;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    level;
    logic          flush_kill;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q[$];
    logic exp_kill = 1'b0;

    arm_pipe_stage_reg #(
        .CTRL_W     (CW),
        .DATA_W     (DW),
        .CLEAR_DATA (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .level      (level),
        .flush_kill (flush_kill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic check_outputs();
        check("out_valid", 256'(out_valid), 256'(q.size() > 0));
        check("out_ctrl", 256'(out_ctrl), (q.size() > 0) ? 256'(q[0].c) : 256'(0));
        if (q.size() > 0) check("out_data", 256'(out_data), 256'(q[0].d));
        check("level", 256'(level), 256'(q.size()));
        check("in_ready", 256'(in_ready), 256'(q.size() < 2));
        check("flush_kill", 256'(flush_kill), 256'(exp_kill));
    endtask

    // Drive one cycle of inputs, advance the queue model across the edge, then compare
    task automatic step(input logic iv, input logic ordy, input logic fl,
                        input logic [CW-1:0] c, input logic [DW-1:0] d);
        logic pop, acc;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_data   = d;
        pop = (q.size() > 0) && ordy;
        acc = iv && (q.size() < 2);
        @(posedge clk);
        exp_kill = fl && (iv || (q.size() - int'(pop)) > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{c: c, d: d});
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, ordy, 1'b0, 9'h1FF, rand_data());
    endtask

    initial begin
        logic [DW-1:0] da, db, dc;

        #4;
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_out_ctrl", 256'(out_ctrl), 256'(0));
        check("reset_out_data", 256'(out_data), 256'(0));
        check("reset_level", 256'(level), 256'(0));
        check("reset_in_ready", 256'(in_ready), 256'(1));
        check("reset_flush_kill", 256'(flush_kill), 256'(0));
        #8 rst_n = 1'b1;

        // First push: 1-cycle latency
        step(1'b1, 1'b1, 1'b0, 9'h1A5, {3'b0, 32'h100, 109'h0});
        check("first_ctrl", 256'(out_ctrl), 256'(9'h1A5));
        check("first_level", 256'(level), 256'(1));
        idle(1'b1);

        // Streaming
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 9'(i + 1), DW'(i * 16 + 3));
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A, B fill, C waits upstream
        da = rand_data();
        db = rand_data();
        dc = rand_data();
        step(1'b1, 1'b0, 1'b0, 9'h0A, da);
        step(1'b1, 1'b0, 1'b0, 9'h0B, db);
        check("bp_level_full", 256'(level), 256'(2));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 9'h0C, dc);
        check("bp_hold_a", 256'(out_data), 256'(da));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 9'h0C, dc);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush in FULL with input pending
        step(1'b1, 1'b0, 1'b0, 9'h11, rand_data());
        step(1'b1, 1'b0, 1'b0, 9'h12, rand_data());
        step(1'b1, 1'b0, 1'b1, 9'h13, rand_data());
        check("flush_full_kill", 256'(flush_kill), 256'(1));
        // Flush while empty and idle
        step(1'b0, 1'b0, 1'b1, 9'h14, rand_data());
        check("flush_empty_kill", 256'(flush_kill), 256'(0));

        // Flush coinciding with the pop of a lone entry
        step(1'b1, 1'b0, 1'b0, 9'h15, rand_data());
        step(1'b0, 1'b1, 1'b1, 9'h16, rand_data());
        check("flush_pop_kill", 256'(flush_kill), 256'(0));

        // Asynchronous reset mid-cycle while FULL
        step(1'b1, 1'b0, 1'b0, 9'h17, rand_data());
        step(1'b1, 1'b0, 1'b0, 9'h18, rand_data());
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        exp_kill = 1'b0;
        check("arst_out_valid", 256'(out_valid), 256'(0));
        check("arst_out_data", 256'(out_data), 256'(0));
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 9'h19, rand_data());
        check("arst_relatency", 256'(out_ctrl), 256'(9'h19));

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), 9'($urandom), rand_data());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
